// File: rtl/obb_pkg.sv
// Shared widths, FSM encodings and covariance pair indexing for the OBB pipeline.
package obb_pkg;

   localparam int OBB_W    = 21;
   localparam int OBB_FRAC = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACCUM = 3'd1,
      MEAN  = 3'd2,
      COV   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [2:0] K_XX = 3'd0;
   localparam logic [2:0] K_XY = 3'd1;
   localparam logic [2:0] K_XZ = 3'd2;
   localparam logic [2:0] K_YY = 3'd3;
   localparam logic [2:0] K_YZ = 3'd4;
   localparam logic [2:0] K_ZZ = 3'd5;

   localparam logic [1:0] AX_X = 2'd0;
   localparam logic [1:0] AX_Y = 2'd1;
   localparam logic [1:0] AX_Z = 2'd2;

   // First and second axis of pair k; out-of-range k falls back to z.
   function automatic logic [1:0] pair_a(input logic [2:0] k);
      case (k)
         K_XX, K_XY, K_XZ: pair_a = AX_X;
         K_YY, K_YZ:       pair_a = AX_Y;
         default:          pair_a = AX_Z;
      endcase
   endfunction

   function automatic logic [1:0] pair_b(input logic [2:0] k);
      case (k)
         K_XX:       pair_b = AX_X;
         K_XY, K_YY: pair_b = AX_Y;
         default:    pair_b = AX_Z;
      endcase
   endfunction

endpackage

// File: rtl/cov_mac.sv
// Signed WxW multiplier with synchronous clear/accumulate; clr together with en loads the product.
module cov_mac #(
   parameter int W  = 21,
   parameter int AW = 42
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic [AW-1:0] acc
);

   logic signed [2*W-1:0] prod;

   assign prod = $signed(a) * $signed(b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= en ? AW'(prod) : '0;
      end else if (en) begin
         acc <= acc + AW'(prod);
      end
   end

endmodule

// File: rtl/cov_accum.sv
// Streams N 3-D points and produces their 3x3 covariance matrix m1..m9.
// Define COV_SAT_EN to clamp out-of-range results instead of wrapping them.
module cov_accum
   import obb_pkg::*;
#(
   parameter int W      = OBB_W,
   parameter int FRAC   = OBB_FRAC,
   parameter int LOG2_N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         pt_valid,
   output logic         pt_ready,
   input  logic [W-1:0] px,
   input  logic [W-1:0] py,
   input  logic [W-1:0] pz,
   output logic [W-1:0] m1,
   output logic [W-1:0] m2,
   output logic [W-1:0] m3,
   output logic [W-1:0] m4,
   output logic [W-1:0] m5,
   output logic [W-1:0] m6,
   output logic [W-1:0] m7,
   output logic [W-1:0] m8,
   output logic [W-1:0] m9,
   output logic         busy,
   output logic         done
);

   localparam int SW = W + LOG2_N;
   localparam int PW = 2 * W;
   localparam int CW = 2 * W + LOG2_N;
   localparam logic [LOG2_N-1:0] LAST_PT = {LOG2_N{1'b1}};

   state_t            state;
   logic [LOG2_N-1:0] cnt;
   logic [2:0]        k;
   logic              accept;

   logic signed [SW-1:0] sum_x, sum_y, sum_z;
   logic signed [W-1:0]  coord [3];
   logic signed [W-1:0]  mu_comb [3];
   logic signed [W-1:0]  mu_q [3];
   logic signed [W-1:0]  mu_src [3];
   logic signed [W-1:0]  shadow [6];
   logic [CW-1:0]        acc_pair [6];

   logic [2:0]           kk;
   logic [W-1:0]         mul_a, mul_b;
   logic                 mul_load;
   logic [PW-1:0]        mul_acc;
   logic signed [CW-1:0] pair_sum, s_ab, cov_full;
   logic signed [W-1:0]  cov_n;

   assign accept   = pt_valid & pt_ready;
   assign coord[0] = $signed(px);
   assign coord[1] = $signed(py);
   assign coord[2] = $signed(pz);

   // Six product-sum accumulators, cleared while idle.
   for (genvar p = 0; p < 6; p++) begin : g_pair
      cov_mac #(.W(W), .AW(CW)) u_mac (
         .clk (clk),
         .rst (rst),
         .clr (state == IDLE),
         .en  (accept),
         .a   (coord[pair_a(3'(p))]),
         .b   (coord[pair_b(3'(p))]),
         .acc (acc_pair[p])
      );
   end

   always_comb begin
      mu_comb[0] = W'(sum_x >>> LOG2_N);
      mu_comb[1] = W'(sum_y >>> LOG2_N);
      mu_comb[2] = W'(sum_z >>> LOG2_N);
      for (int j = 0; j < 3; j++) begin
         mu_src[j] = (state == MEAN) ? mu_comb[j] : mu_q[j];
      end
   end

   // Shared multiplier runs one pair ahead: MEAN loads pair 0, COV k loads pair k+1.
   assign kk       = (state == MEAN) ? K_XX : k + 3'd1;
   assign mul_a    = mu_src[pair_a(kk)];
   assign mul_b    = mu_src[pair_b(kk)];
   assign mul_load = (state == MEAN) || (state == COV);

   cov_mac #(.W(W), .AW(PW)) u_cov_mul (
      .clk (clk),
      .rst (rst),
      .clr (mul_load),
      .en  (mul_load),
      .a   (mul_a),
      .b   (mul_b),
      .acc (mul_acc)
   );

   always_comb begin
      case (k)
         K_XX:    pair_sum = $signed(acc_pair[0]);
         K_XY:    pair_sum = $signed(acc_pair[1]);
         K_XZ:    pair_sum = $signed(acc_pair[2]);
         K_YY:    pair_sum = $signed(acc_pair[3]);
         K_YZ:    pair_sum = $signed(acc_pair[4]);
         default: pair_sum = $signed(acc_pair[5]);
      endcase
      s_ab     = (pair_sum >>> LOG2_N) >>> FRAC;
      cov_full = s_ab - CW'($signed(mul_acc) >>> FRAC);
   end

`ifdef COV_SAT_EN
   localparam longint SAT_MAXL = (longint'(1) << (W - 1)) - 1;
   localparam logic signed [CW-1:0] SAT_MAX = CW'(SAT_MAXL);
   localparam logic signed [CW-1:0] SAT_MIN = CW'(-SAT_MAXL - 1);

   always_comb begin
      if (cov_full > SAT_MAX)      cov_n = W'(SAT_MAX);
      else if (cov_full < SAT_MIN) cov_n = W'(SAT_MIN);
      else                         cov_n = W'(cov_full);
   end
`else
   assign cov_n = W'(cov_full);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         k        <= '0;
         sum_x    <= '0;
         sum_y    <= '0;
         sum_z    <= '0;
         pt_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int j = 0; j < 3; j++) mu_q[j] <= '0;
         for (int j = 0; j < 6; j++) shadow[j] <= '0;
         {m1, m2, m3, m4, m5, m6, m7, m8, m9} <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cnt   <= '0;
               sum_x <= '0;
               sum_y <= '0;
               sum_z <= '0;
               if (start) begin
                  state    <= ACCUM;
                  pt_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               if (accept) begin
                  sum_x <= sum_x + SW'(coord[0]);
                  sum_y <= sum_y + SW'(coord[1]);
                  sum_z <= sum_z + SW'(coord[2]);
                  cnt   <= cnt + 1'b1;
                  if (cnt == LAST_PT) begin
                     state    <= MEAN;
                     pt_ready <= 1'b0;
                  end
               end
            end
            MEAN: begin
               for (int j = 0; j < 3; j++) mu_q[j] <= mu_comb[j];
               k     <= K_XX;
               state <= COV;
            end
            COV: begin
               shadow[k] <= cov_n;
               k         <= k + 3'd1;
               // Last pair goes straight to m9 so the matrix and done appear together.
               if (k == K_ZZ) begin
                  state <= DONE;
                  done  <= 1'b1;
                  m1 <= shadow[K_XX];
                  m2 <= shadow[K_XY];
                  m3 <= shadow[K_XZ];
                  m4 <= shadow[K_XY];
                  m5 <= shadow[K_YY];
                  m6 <= shadow[K_YZ];
                  m7 <= shadow[K_XZ];
                  m8 <= shadow[K_YZ];
                  m9 <= cov_n;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
